// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch sequencer.
// State encodings and PC-select codes used by fetch_ctrl and its neighbours.
package fetch_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] REQ    = 3'd1;
    localparam logic [2:0] HOLD   = 3'd2;
    localparam logic [2:0] UPDATE = 3'd3;
    localparam logic [2:0] ERR    = 3'd4;

    localparam int unsigned PC_INCR = 4;

    localparam logic PC_SRC_SEQ = 1'b0;
    localparam logic PC_SRC_BR  = 1'b1;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch sequencer bus: PC register controls, instruction memory
// port and the decode-side valid/ready handshake.
interface fetch_ctrl_if #(
    parameter int data_Size = 32
) ();

    logic [data_Size-1:0] pc_in;
    logic                 pc_load;
    logic                 pc_src;
    logic                 imem_req;
    logic [data_Size-1:0] imem_addr;
    logic                 imem_ack;
    logic [data_Size-1:0] imem_rdata;
    logic [data_Size-1:0] instr;
    logic                 instr_valid;
    logic                 instr_ready;
    logic                 branch_taken;
    logic                 fetch_err;

    modport master (
        input  pc_in, imem_ack, imem_rdata,
        input  instr_ready, branch_taken,
        output pc_load, pc_src, imem_req, imem_addr,
        output instr, instr_valid, fetch_err
    );

    modport slave (
        output pc_in, imem_ack, imem_rdata,
        output instr_ready, branch_taken,
        input  pc_load, pc_src, imem_req, imem_addr,
        input  instr, instr_valid, fetch_err
    );

endinterface

// File: rtl/fetch_ctrl.sv
// Multi-cycle fetch sequencer: request, hold for decode, update PC.
// A sticky error is raised when memory leaves MAX_WAIT requests unanswered.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int data_Size = 32,
    parameter int MAX_WAIT  = 15
) (
    input  logic         clk,
    input  logic         areset,
    fetch_ctrl_if.master bus
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [2:0]           r_state;
    logic [2:0]           w_next;
    logic [CW-1:0]        r_wait;
    logic [data_Size-1:0] r_instr;
    logic                 r_br;
    logic                 w_ack;
    logic                 w_hs;
    logic                 w_tmo;

    assign w_ack = (r_state == REQ) && bus.imem_ack;
    assign w_hs  = (r_state == HOLD) && bus.instr_ready;
    // This miss is the MAX_WAIT-th in a row; an ack in the same cycle still wins.
    assign w_tmo = (r_wait == CW'(MAX_WAIT - 1));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = REQ;
            REQ: begin
                if (bus.imem_ack)
                    w_next = HOLD;
                else if (w_tmo)
                    w_next = ERR;
            end
            HOLD: begin
                if (bus.instr_ready)
                    w_next = UPDATE;
            end
            UPDATE:  w_next = REQ;
            ERR:     w_next = ERR;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_state <= IDLE;
            r_wait  <= '0;
            r_instr <= '0;
            r_br    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_ack) begin
                r_instr <= bus.imem_rdata;
                r_wait  <= '0;
            end else if (r_state == REQ) begin
                r_wait <= r_wait + CW'(1);
            end
            if (w_hs)
                r_br <= bus.branch_taken;
        end
    end

    assign bus.imem_req    = (r_state == REQ);
    assign bus.imem_addr   = (r_state == REQ) ? bus.pc_in : '0;
    assign bus.instr       = r_instr;
    assign bus.instr_valid = (r_state == HOLD);
    assign bus.pc_load     = (r_state == UPDATE);
    assign bus.pc_src      = (r_state == UPDATE) ? r_br : PC_SRC_SEQ;
    assign bus.fetch_err   = (r_state == ERR);

endmodule
